// File: rtl/uart_pkg.sv
// Shared types for the word-to-byte UART feeder: serializer states and FIFO entry layout.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_ACK,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [1:0]  nbytes;
    logic [31:0] data;
  } entry_t;

  localparam int unsigned EntryWidth = $bits(entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO with occupancy count; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH      = 34,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign full    = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

  // Pointers are exactly DEPTH_LOG2 bits so they wrap on their own.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_word_feeder.sv
// Buffers 32-bit words and feeds them LSB byte first to a byte UART transmitter,
// pacing each byte on the transmitter's tx_busy handshake.
module uart_tx_word_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [31:0]         wr_data,
  input  logic [1:0]          wr_nbytes,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  output logic                idle,
  output logic                overflow,
  output logic [7:0]          sdata,
  output logic                tx_start,
  input  logic                tx_busy
);

  entry_t                wr_entry, rd_entry;
  logic [EntryWidth-1:0] rd_bits;
  logic                  pop, empty;

  state_e      state_q;
  logic [31:0] shift_q;
  logic [1:0]  rem_q;
  logic [7:0]  sdata_q;
  logic        tx_start_q, overflow_q;

  assign wr_entry = '{nbytes: wr_nbytes, data: wr_data};
  assign rd_entry = rd_bits;
  assign pop      = (state_q == S_IDLE) && !empty;

  sync_fifo #(
    .WIDTH      (EntryWidth),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (wr_en),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_bits),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // tx_start is registered and set only on entry to S_START, so it is high for
  // exactly the one cycle spent there.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      rem_q      <= '0;
      sdata_q    <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (wr_en && full) overflow_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q    <= rd_entry.data;
            rem_q      <= rd_entry.nbytes;
            sdata_q    <= rd_entry.data[7:0];
            tx_start_q <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: state_q <= S_ACK;
        S_ACK: begin
          if (tx_busy) state_q <= S_DONE;
        end
        S_DONE: begin
          if (!tx_busy) begin
            if (rem_q == 2'd0) begin
              state_q <= S_IDLE;
            end else begin
              shift_q    <= shift_q >> 8;
              sdata_q    <= shift_q[15:8];
              rem_q      <= rem_q - 2'd1;
              tx_start_q <= 1'b1;
              state_q    <= S_START;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign idle     = (count == '0) && (state_q == S_IDLE);
  assign overflow = overflow_q;
  assign sdata    = sdata_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Self-checking bench: directed scenarios with random words, a transmitter model and
// a queue-based reference of the expected byte stream and pulse spacing.
module tb_uart_tx_word_feeder;

  localparam int unsigned DEPTH_LOG2 = 4;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                wr_en = 1'b0;
  logic [31:0]         wr_data = '0;
  logic [1:0]          wr_nbytes = '0;
  logic                full, idle, overflow, tx_start;
  logic [DEPTH_LOG2:0] count;
  logic [7:0]          sdata;
  logic                tx_busy = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_word_feeder #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_nbytes (wr_nbytes),
    .full      (full),
    .count     (count),
    .idle      (idle),
    .overflow  (overflow),
    .sdata     (sdata),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy)
  );

  // Transmitter model: busy rises one edge after a sampled pulse (plus extra_delay),
  // stays up for frame_len edges, or indefinitely while hold is set.
  int         frame_len = 4;
  int         extra_delay = 0;
  bit         hold = 0;
  int         busy_left = 0;
  int         delay_left = 0;
  bit         pending = 0;
  int         cyc = 0;
  int         double_hi = 0;
  bit         prev_st = 0;
  logic [7:0] got[$];
  int         got_cyc[$];

  always @(posedge clk) begin : tx_model
    logic       st, rs;
    logic [7:0] sd;
    st = tx_start;
    sd = sdata;
    rs = rstn;
    cyc++;
    if (st && prev_st) double_hi++;
    prev_st = st;
    if (st) begin
      got.push_back(sd);
      got_cyc.push_back(cyc);
    end
    #1;
    if (!rs) begin
      tx_busy   = 1'b0;
      pending   = 0;
      busy_left = 0;
    end else begin
      if (pending) begin
        delay_left--;
        if (delay_left == 0) begin
          pending   = 0;
          tx_busy   = 1'b1;
          busy_left = frame_len;
        end
      end else if (busy_left > 1) begin
        busy_left--;
      end else if (busy_left == 1 && !hold) begin
        busy_left = 0;
        tx_busy   = 1'b0;
      end
      if (st) begin
        if (extra_delay == 0) begin
          tx_busy   = 1'b1;
          busy_left = frame_len;
        end else begin
          pending    = 1;
          delay_left = extra_delay;
        end
      end
    end
  end

  // Reference: every accepted word contributes nbytes+1 bytes, LSB first.
  logic [7:0] exp_b[$];
  bit         exp_first[$];
  int         push_cyc = 0;

  task automatic model_push(input logic [31:0] d, input logic [1:0] nb);
    for (int i = 0; i <= int'(nb); i++) begin
      exp_b.push_back(8'(d >> (8 * i)));
      exp_first.push_back(i == 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] nb, input bit accept);
    wr_en     = 1'b1;
    wr_data   = d;
    wr_nbytes = nb;
    tick();
    push_cyc = cyc;
    wr_en    = 1'b0;
    if (accept) model_push(d, nb);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = idle && !tx_busy && (got.size() >= exp_b.size());
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_nbytes"}, 64'(got.size()), 64'(exp_b.size()));
    for (int i = 0; i < got.size() && i < exp_b.size(); i++) begin
      check({tag, "_byte"}, 64'(got[i]), 64'(exp_b[i]));
    end
    check({tag, "_double_pulse"}, 64'(double_hi), 64'd0);
  endtask

  task automatic check_gaps(input string tag);
    for (int i = 1; i < got_cyc.size() && i < exp_first.size(); i++) begin
      check(tag, 64'(got_cyc[i] - got_cyc[i-1]),
            64'(frame_len + extra_delay + 2 + (exp_first[i] ? 1 : 0)));
    end
  endtask

  task automatic clear();
    got.delete();
    got_cyc.delete();
    exp_b.delete();
    exp_first.delete();
    double_hi = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [31:0] w;
    int          p;
    bit          seen;

    // Reset state
    rstn = 1'b0;
    repeat (3) tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_sdata", 64'(sdata), 64'd0);
    rstn = 1'b1;
    tick();

    // Four-byte word
    push(32'h4433_2211, 2'd3, 1);
    wait_drain("t1_drain", 300);
    compare_stream("t1");
    check_gaps("t1_gap");
    check("t1_idle", 64'(idle), 64'd1);
    clear();

    // Single byte and first-pulse latency
    push(32'h0000_00A5, 2'd0, 1);
    p = push_cyc;
    wait_drain("t2_drain", 100);
    compare_stream("t2");
    if (got_cyc.size() > 0) check("t2_latency", 64'(got_cyc[0] - p), 64'd2);
    clear();

    // Fill to capacity behind a stalled transmitter, then overflow
    hold = 1;
    push($urandom, 2'd0, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = tx_busy;
    end
    check("t3_busy_held", 64'(seen), 64'd1);
    for (int k = 0; k < 17; k++) begin
      push($urandom, 2'($urandom_range(3)), k < 16);
      if (k == 15) begin
        check("t3_count16", 64'(count), 64'd16);
        check("t3_full", 64'(full), 64'd1);
        check("t3_no_overflow_yet", 64'(overflow), 64'd0);
      end
      if (k == 16) begin
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_count_held", 64'(count), 64'd16);
      end
    end
    hold = 0;
    wait_drain("t3_drain", 4000);
    compare_stream("t3");
    check("t3_overflow_sticky", 64'(overflow), 64'd1);
    clear();

    // Reset during S_DONE of the second byte
    w = $urandom;
    push(w, 2'd3, 1);
    push($urandom, 2'($urandom_range(3)), 1);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = (got.size() >= 2);
    end
    check("t5_second_byte", 64'(seen), 64'd1);
    tick();
    check("t5_count_before", 64'(count), 64'd1);
    rstn = 1'b0;
    tick();
    check("t5_tx_start", 64'(tx_start), 64'd0);
    check("t5_count", 64'(count), 64'd0);
    check("t5_idle", 64'(idle), 64'd1);
    check("t5_overflow", 64'(overflow), 64'd0);
    rstn = 1'b1;
    repeat (30) tick();
    check("t5_no_more_pulses", 64'(got.size()), 64'd2);
    if (got.size() >= 2) begin
      check("t5_b0", 64'(got[0]), 64'(w[7:0]));
      check("t5_b1", 64'(got[1]), 64'(w[15:8]));
    end
    clear();

    // Push every cycle while draining
    frame_len = 3;
    for (int k = 0; k < 8; k++) begin
      push($urandom, 2'($urandom_range(3)), 1);
      if (k < 2) check("t4_count", 64'(count), 64'd1);
    end
    wait_drain("t4_drain", 1000);
    compare_stream("t4");
    check_gaps("t4_gap");
    clear();

    // Transmitter raising busy three cycles late
    extra_delay = 3;
    push($urandom, 2'd3, 1);
    push($urandom, 2'($urandom_range(3)), 1);
    wait_drain("t6_drain", 500);
    compare_stream("t6");
    check_gaps("t6_gap");
    extra_delay = 0;
    clear();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
